// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: write/read/issue ports, scoreboard state and init status.
// master = ID/WB pipeline side, slave = register file.
interface regfile_mp_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned NUM_WR = 1
);
  localparam int unsigned DEPTH = 2**ADDR_W;

  logic                       init_done;
  logic [NUM_WR-1:0]          wr_en;
  logic [NUM_WR*ADDR_W-1:0]   wr_addr;
  logic [NUM_WR*DATA_W-1:0]   wr_data;
  logic [NUM_RD-1:0]          rd_en;
  logic [NUM_RD*ADDR_W-1:0]   rd_addr;
  logic [NUM_RD*DATA_W-1:0]   rd_data;
  logic [NUM_RD-1:0]          rd_busy;
  logic                       sb_set_en;
  logic [ADDR_W-1:0]          sb_set_addr;
  logic [DEPTH-1:0]           busy_vec;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr, sb_set_en, sb_set_addr,
    input  init_done, rd_data, rd_busy, busy_vec
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr, sb_set_en, sb_set_addr,
    output init_done, rd_data, rd_busy, busy_vec
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port GPR file with optional write bypass, hardwired zero register,
// per-register busy scoreboard and a post-reset clear sequencer.
module regfile_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 1,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic        clk,
  input  logic        rst,
  regfile_mp_if.slave bus
);
  localparam int unsigned DEPTH = 2**ADDR_W;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0]   r_regs [DEPTH];
  logic [DEPTH-1:0]    r_busy, w_busy_nxt;
  logic                w_run;
  logic [NUM_RD*DATA_W-1:0] w_rd_data;
  logic [NUM_RD-1:0]        w_rd_busy;

  assign w_run = (r_state == S_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (r_state == S_INIT) begin
      w_cnt_nxt = r_cnt + 1'b1;
      if (r_cnt == '1) w_state_nxt = S_RUN;
    end
  end

  // Array has no reset; the INIT sweep clears it one entry per cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!w_run) begin
        r_regs[r_cnt] <= '0;
      end else begin
        for (int unsigned k = 0; k < NUM_WR; k++) begin
          if (bus.wr_en[k] &&
              !((ZERO_REG != 0) && (bus.wr_addr[k*ADDR_W +: ADDR_W] == '0)))
            r_regs[bus.wr_addr[k*ADDR_W +: ADDR_W]] <= bus.wr_data[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Clears applied before the set so a same-address set wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_run) begin
      for (int unsigned k = 0; k < NUM_WR; k++) begin
        if (bus.wr_en[k]) w_busy_nxt[bus.wr_addr[k*ADDR_W +: ADDR_W]] = 1'b0;
      end
      if (bus.sb_set_en) w_busy_nxt[bus.sb_set_addr] = 1'b1;
    end
    if (ZERO_REG != 0) w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_busy_nxt;
  end

  always_comb begin
    w_rd_data = '0;
    w_rd_busy = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      if (w_run && bus.rd_en[i] &&
          !((ZERO_REG != 0) && (bus.rd_addr[i*ADDR_W +: ADDR_W] == '0))) begin
        w_rd_data[i*DATA_W +: DATA_W] = r_regs[bus.rd_addr[i*ADDR_W +: ADDR_W]];
        w_rd_busy[i] = r_busy[bus.rd_addr[i*ADDR_W +: ADDR_W]];
        if (BYPASS != 0) begin
          for (int unsigned k = 0; k < NUM_WR; k++) begin
            if (bus.wr_en[k] &&
                (bus.wr_addr[k*ADDR_W +: ADDR_W] == bus.rd_addr[i*ADDR_W +: ADDR_W])) begin
              w_rd_data[i*DATA_W +: DATA_W] = bus.wr_data[k*DATA_W +: DATA_W];
              w_rd_busy[i] = 1'b0;
            end
          end
        end
      end
    end
  end

  assign bus.rd_data   = w_rd_data;
  assign bus.rd_busy   = w_rd_busy;
  assign bus.busy_vec  = r_busy;
  assign bus.init_done = w_run;
endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp: a 2-write-port bypassing instance
// and a 1-write-port non-bypassing instance driven side by side.
module tb_regfile_mp;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2)) bus_a ();
  regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(1)) bus_b ();

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .BYPASS(1), .ZERO_REG(1))
    u_dut (.clk(clk), .rst(rst), .bus(bus_a));

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(1), .BYPASS(0), .ZERO_REG(1))
    u_nb (.clk(clk), .rst(rst), .bus(bus_b));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus_a.wr_en = '0; bus_a.wr_addr = '0; bus_a.wr_data = '0;
    bus_a.rd_en = '0; bus_a.rd_addr = '0;
    bus_a.sb_set_en = 1'b0; bus_a.sb_set_addr = '0;
    bus_b.wr_en = '0; bus_b.wr_addr = '0; bus_b.wr_data = '0;
    bus_b.rd_en = '0; bus_b.rd_addr = '0;
    bus_b.sb_set_en = 1'b0; bus_b.sb_set_addr = '0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("reset_init_done", 64'(bus_a.init_done), 64'd0);
    chk("reset_busy_vec", 64'(bus_a.busy_vec), 64'd0);

    // INIT: 31 cycles still not done; writes/sb_set in the last INIT cycle are ignored
    repeat (31) step();
    chk("init_done_cycle31", 64'(bus_a.init_done), 64'd0);
    bus_a.wr_en = 2'b01; bus_a.wr_addr[4:0] = 5'd4; bus_a.wr_data[31:0] = 32'h55;
    bus_a.sb_set_en = 1'b1; bus_a.sb_set_addr = 5'd4;
    bus_a.rd_en = 2'b01; bus_a.rd_addr[4:0] = 5'd4;
    #1;
    chk("init_read_zero", 64'(bus_a.rd_data[31:0]), 64'd0);
    step();
    idle();
    chk("init_done_run", 64'(bus_a.init_done), 64'd1);
    chk("init_done_nb", 64'(bus_b.init_done), 64'd1);
    chk("init_sbset_ignored", 64'(bus_a.busy_vec), 64'd0);

    // every register cleared
    bus_a.rd_en = 2'b01;
    for (int a = 0; a < 32; a++) begin
      bus_a.rd_addr[4:0] = 5'(a);
      #1;
      chk($sformatf("clear_r%0d", a), 64'(bus_a.rd_data[31:0]), 64'd0);
    end
    idle();

    // same-cycle bypass on port 1 vs. array-only read
    bus_a.wr_en = 2'b01; bus_a.wr_addr[4:0] = 5'd5; bus_a.wr_data[31:0] = 32'hDEADBEEF;
    bus_a.rd_en = 2'b10; bus_a.rd_addr[9:5] = 5'd5;
    bus_b.wr_en = 1'b1; bus_b.wr_addr = 5'd5; bus_b.wr_data = 32'hDEADBEEF;
    bus_b.rd_en = 2'b10; bus_b.rd_addr[9:5] = 5'd5;
    #1;
    chk("bypass_r5", 64'(bus_a.rd_data[63:32]), 64'hDEADBEEF);
    chk("nobypass_r5_old", 64'(bus_b.rd_data[63:32]), 64'd0);
    step();
    bus_a.wr_en = '0; bus_b.wr_en = '0;
    #1;
    chk("r5_next", 64'(bus_a.rd_data[63:32]), 64'hDEADBEEF);
    chk("nb_r5_next", 64'(bus_b.rd_data[63:32]), 64'hDEADBEEF);
    idle();

    // zero register: write and issue both dropped
    bus_a.wr_en = 2'b01; bus_a.wr_addr[4:0] = 5'd0; bus_a.wr_data[31:0] = 32'h12345678;
    bus_a.sb_set_en = 1'b1; bus_a.sb_set_addr = 5'd0;
    bus_a.rd_en = 2'b01; bus_a.rd_addr[4:0] = 5'd0;
    #1;
    chk("r0_bypass_zero", 64'(bus_a.rd_data[31:0]), 64'd0);
    step();
    bus_a.wr_en = '0; bus_a.sb_set_en = 1'b0;
    #1;
    chk("r0_read_zero", 64'(bus_a.rd_data[31:0]), 64'd0);
    chk("r0_busy_zero", 64'(bus_a.busy_vec[0]), 64'd0);
    idle();

    // both write ports on r7: port 1 wins
    bus_a.wr_en = 2'b11;
    bus_a.wr_addr[4:0] = 5'd7; bus_a.wr_data[31:0]  = 32'h1111;
    bus_a.wr_addr[9:5] = 5'd7; bus_a.wr_data[63:32] = 32'h2222;
    bus_a.rd_en = 2'b01; bus_a.rd_addr[4:0] = 5'd7;
    #1;
    chk("dual_wr_bypass_r7", 64'(bus_a.rd_data[31:0]), 64'h2222);
    step();
    bus_a.wr_en = '0;
    #1;
    chk("dual_wr_r7", 64'(bus_a.rd_data[31:0]), 64'h2222);
    idle();

    // scoreboard
    bus_a.sb_set_en = 1'b1; bus_a.sb_set_addr = 5'd9;
    bus_a.rd_en = 2'b01; bus_a.rd_addr[4:0] = 5'd9;
    #1;
    chk("sb_set_not_yet", 64'(bus_a.rd_busy[0]), 64'd0);
    step();
    bus_a.sb_set_en = 1'b0;
    #1;
    chk("sb_r9_busy", 64'(bus_a.rd_busy[0]), 64'd1);
    chk("sb_busy_vec", 64'(bus_a.busy_vec), 64'h200);
    bus_a.wr_en = 2'b10; bus_a.wr_addr[9:5] = 5'd9; bus_a.wr_data[63:32] = 32'h77;
    bus_a.sb_set_en = 1'b1; bus_a.sb_set_addr = 5'd9;
    #1;
    chk("sb_bypass_not_busy", 64'(bus_a.rd_busy[0]), 64'd0);
    step();
    bus_a.wr_en = '0; bus_a.sb_set_en = 1'b0;
    #1;
    chk("sb_set_wins", 64'(bus_a.rd_busy[0]), 64'd1);
    chk("sb_set_wins_data", 64'(bus_a.rd_data[31:0]), 64'h77);
    bus_a.wr_en = 2'b01; bus_a.wr_addr[4:0] = 5'd9; bus_a.wr_data[31:0] = 32'h99;
    step();
    bus_a.wr_en = '0;
    #1;
    chk("sb_clear_r9", 64'(bus_a.rd_busy[0]), 64'd0);
    chk("sb_clear_vec", 64'(bus_a.busy_vec), 64'd0);
    chk("r9_data", 64'(bus_a.rd_data[31:0]), 64'h99);
    idle();

    // mid-run reset
    bus_a.wr_en = 2'b01; bus_a.wr_addr[4:0] = 5'd3; bus_a.wr_data[31:0] = 32'hAA;
    bus_a.sb_set_en = 1'b1; bus_a.sb_set_addr = 5'd12;
    step();
    idle();
    bus_a.rd_en = 2'b01; bus_a.rd_addr[4:0] = 5'd3; bus_a.rd_addr[9:5] = 5'd12;
    #1;
    chk("pre_rst_r3", 64'(bus_a.rd_data[31:0]), 64'hAA);
    chk("pre_rst_busy", 64'(bus_a.busy_vec), 64'h1000);
    chk("rd_en0_data", 64'(bus_a.rd_data[63:32]), 64'd0);
    chk("rd_en0_busy", 64'(bus_a.rd_busy[1]), 64'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_busy_vec", 64'(bus_a.busy_vec), 64'd0);
    chk("rst_init_done", 64'(bus_a.init_done), 64'd0);
    chk("rst_read_zero", 64'(bus_a.rd_data[31:0]), 64'd0);
    repeat (31) step();
    chk("reinit_cycle31", 64'(bus_a.init_done), 64'd0);
    step();
    chk("reinit_done", 64'(bus_a.init_done), 64'd1);
    #1;
    chk("reinit_r3_zero", 64'(bus_a.rd_data[31:0]), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
